// File: rtl/rr_mux_arb_pkg.sv
// Shared arbiter helpers: circular first-set search used by round-robin arbiters.
// Vectors are RR_MAX_N wide; callers zero-extend their N-bit vectors.
package rr_mux_arb_pkg;

  localparam int unsigned RR_MAX_N = 64;

  typedef logic [RR_MAX_N-1:0] rr_vec_t;

  // First set bit of req strictly above the one-hot last, wrapping to bit 0.
  // Zero req gives zero; the result is always one-hot or zero.
  function automatic rr_vec_t rr_first(
    input rr_vec_t req,
    input rr_vec_t last
  );
    rr_vec_t above;
    rr_vec_t hi;
    above = ~((last << 1) - rr_vec_t'(1));
    hi    = req & above;
    if (|hi) return hi & (~hi + rr_vec_t'(1));
    return req & (~req + rr_vec_t'(1));
  endfunction

endpackage

// File: rtl/mux.sv
// One-hot AND-OR multiplexer.
// Ports: i_sel one-hot/zero select, i_data packed words, o_data selected word.
module mux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N-1:0]        i_sel,
  input  logic [N-1:0][W-1:0] i_data,
  output logic [W-1:0]        o_data
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < N; i++) begin
      o_data = o_data | (i_data[i] & {W{i_sel[i]}});
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin arbiter of N valid/ready requesters onto one registered channel.
// Ports: clk, arst_n, i_req_* requests, o_req_rdy grants, o_vld/o_data/o_sel out, i_rdy.
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [N-1:0]        i_req_vld,
  input  logic [N-1:0][W-1:0] i_req_data,
  input  logic [N-1:0]        i_req_mask,
  output logic [N-1:0]        o_req_rdy,
  output logic                o_vld,
  output logic [W-1:0]        o_data,
  output logic [N-1:0]        o_sel,
  input  logic                i_rdy
);

  localparam logic [N-1:0] LAST_RST = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0] eff;
  logic [N-1:0] grant;
  logic [N-1:0] last;
  logic [W-1:0] mux_data;
  logic         free;
  rr_vec_t      grant_w;

  assign eff     = i_req_vld & i_req_mask;
  assign grant_w = rr_first(rr_vec_t'(eff), rr_vec_t'(last));
  assign grant   = grant_w[N-1:0];

  assign free      = ~o_vld | i_rdy;
  assign o_req_rdy = grant & {N{free}};

  mux #(
    .N(N),
    .W(W)
  ) u_mux (
    .i_sel  (grant),
    .i_data (i_req_data),
    .o_data (mux_data)
  );

  // Pointer only advances on an accepted transfer, so a stalled
  // winner keeps its priority.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_vld  <= 1'b0;
      o_data <= '0;
      o_sel  <= '0;
      last   <= LAST_RST;
    end else if (free) begin
      o_vld <= |grant;
      if (|grant) begin
        o_data <= mux_data;
        o_sel  <= grant;
        last   <= grant;
      end
    end
  end

  a_rdy_oh: assert property (
    @(posedge clk) disable iff (!arst_n) $onehot0(o_req_rdy));

  a_grant_oh: assert property (
    @(posedge clk) disable iff (!arst_n) $onehot0(grant_w));

  a_sel_oh: assert property (
    @(posedge clk) disable iff (!arst_n) o_vld |-> $onehot(o_sel));

  for (genvar j = 0; j < N; j++) begin : g_hold
    a_vld_hold: assert property (
      @(posedge clk) disable iff (!arst_n)
      i_req_vld[j] & ~o_req_rdy[j] |=> i_req_vld[j]);
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb (N=4, W=8).
// Hand-computed grants, data and select per cycle; one summary line at end.
module tb_rr_mux_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic                clk;
  logic                arst_n;
  logic [N-1:0]        i_req_vld;
  logic [N-1:0][W-1:0] i_req_data;
  logic [N-1:0]        i_req_mask;
  logic [N-1:0]        o_req_rdy;
  logic                o_vld;
  logic [W-1:0]        o_data;
  logic [N-1:0]        o_sel;
  logic                i_rdy;

  int n_chk;
  int n_err;

  rr_mux_arb #(
    .N(N),
    .W(W)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_req_vld  (i_req_vld),
    .i_req_data (i_req_data),
    .i_req_mask (i_req_mask),
    .o_req_rdy  (o_req_rdy),
    .o_vld      (o_vld),
    .o_data     (o_data),
    .o_sel      (o_sel),
    .i_rdy      (i_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n     = 1'b0;
    i_req_vld  = '0;
    i_req_mask = '0;
    i_rdy      = 1'b0;
    i_req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic out_chk(
    input string      tag,
    input logic [7:0] d,
    input logic [3:0] s
  );
    chk({tag, "_vld"}, 32'(o_vld), 32'd1);
    chk({tag, "_data"}, 32'(o_data), 32'(d));
    chk({tag, "_sel"}, 32'(o_sel), 32'(s));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    // Reset state
    do_reset();
    #1;
    chk("rst_vld", 32'(o_vld), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_sel", 32'(o_sel), 32'd0);
    chk("rst_rdy", 32'(o_req_rdy), 32'd0);

    // 1: all valid, full throughput, rotation 0..3 then 0
    i_req_vld  = 4'b1111;
    i_req_mask = 4'b1111;
    i_rdy      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t1_rdy", 32'(o_req_rdy), 32'(4'b0001 << (i % 4)));
      cyc();
      out_chk("t1", 8'h10 + 8'(i % 4), 4'b0001 << (i % 4));
    end

    // 2: single requester, one-cycle latency, then empties
    do_reset();
    i_req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    i_req_vld  = 4'b0100;
    i_req_mask = 4'b1111;
    i_rdy      = 1'b1;
    #1;
    chk("t2_rdy", 32'(o_req_rdy), 32'b0100);
    cyc();
    out_chk("t2", 8'hA5, 4'b0100);
    i_req_vld = '0;
    cyc();
    chk("t2_empty", 32'(o_vld), 32'd0);
    chk("t2_hold", 32'(o_data), 32'hA5);

    // 3: stall for three cycles, pointer holds, then req1
    do_reset();
    i_req_vld  = 4'b1111;
    i_req_mask = 4'b1111;
    i_rdy      = 1'b1;
    cyc();
    out_chk("t3a", 8'h10, 4'b0001);
    i_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_rdy", 32'(o_req_rdy), 32'd0);
      cyc();
      out_chk("t3_stall", 8'h10, 4'b0001);
    end
    i_rdy = 1'b1;
    #1;
    chk("t3_resume_rdy", 32'(o_req_rdy), 32'b0010);
    cyc();
    out_chk("t3b", 8'h11, 4'b0010);

    // 4: mask 1010 alternates req1/req3 only
    do_reset();
    i_req_vld  = 4'b1111;
    i_req_mask = 4'b1010;
    i_rdy      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_rdy", 32'(o_req_rdy), (i % 2 == 0) ? 32'b0010 : 32'b1000);
      cyc();
      if (i % 2 == 0) out_chk("t4", 8'h11, 4'b0010);
      else            out_chk("t4", 8'h13, 4'b1000);
    end

    // 5: wrap-around after last=3
    do_reset();
    i_req_vld  = 4'b1000;
    i_req_mask = 4'b1111;
    i_rdy      = 1'b1;
    cyc();
    out_chk("t5a", 8'h13, 4'b1000);
    i_req_vld = 4'b1001;
    #1;
    chk("t5_wrap_rdy", 32'(o_req_rdy), 32'b0001);
    cyc();
    out_chk("t5b", 8'h10, 4'b0001);
    #1;
    chk("t5_next_rdy", 32'(o_req_rdy), 32'b1000);
    cyc();
    out_chk("t5c", 8'h13, 4'b1000);

    // 6: async reset mid-transfer, then lowest eligible first
    do_reset();
    i_req_vld  = 4'b1111;
    i_req_mask = 4'b1111;
    i_rdy      = 1'b1;
    cyc();
    cyc();
    out_chk("t6a", 8'h11, 4'b0010);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(o_vld), 32'd0);
    chk("t6_rst_data", 32'(o_data), 32'd0);
    chk("t6_rst_sel", 32'(o_sel), 32'd0);
    @(negedge clk);
    i_req_mask = 4'b1100;
    arst_n     = 1'b1;
    #1;
    chk("t6_first_rdy", 32'(o_req_rdy), 32'b0100);
    cyc();
    out_chk("t6b", 8'h12, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
